i2c_sipo_rx: RTL
================

Name: i2c_sipo_rx

Overview:
Receive-side deserializer for the I2C slave. It complements the byte transmit shifter.
- Oversamples the raw SCL/SDA pins in the clk domain.
- Detects START, repeated START and STOP conditions.
- Shifts SDA in MSB-first on SCL rising edges and presents each completed word in parallel.
- Drives the ACK/NACK bit on the following SCL cycle.
It sits between the pad interface and the slave address/register control FSM.

Parameters:
DEPTH, 8, bits per received word, excluding the ACK bit (must be >= 2).

Ports:
clk  input  1  global clock; must be >= 8x SCL frequency
rst_n  input  1  synchronous active-low reset
en  input  1  device enable; 0 forces IDLE
scl_in  input  1  raw SCL pin level (asynchronous)
sda_in  input  1  raw SDA pin level (asynchronous)
ack_en  input  1  1 = ACK (pull SDA low) after the word; 0 = NACK
parallel_out  output  DEPTH  last completed word, MSB = first bit received
data_valid  output  1  one-cycle pulse when parallel_out updates
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
sda_oe  output  1  1 = drive SDA low (open-drain enable)
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset is synchronous, active-low, on clk rising edge; clock clk. While rst_n=0, all of the following are 0: outputs, state (IDLE), bit counter, shift register and sync flops.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer (scl_s, sda_s), then one delay flop (scl_q, sda_q).
  - scl_rise = scl_s & ~scl_q; scl_fall = ~scl_s & scl_q.
  - start = sda_q & ~sda_s & scl_s; stop = ~sda_q & sda_s & scl_s.
  - Event detection occurs 3 clk cycles after a pin change.
- start_det and stop_det pulse for 1 cycle in the cycle the event is detected, in any state while en=1.
- State priority each cycle: rst_n=0 > en=0 > stop > start > SCL edges.
- States:
  - IDLE: ignores SCL edges.
    - start -> RECV; bit_cnt=0, shift=0.
  - RECV:
    - scl_rise: shift <= {shift[DEPTH-2:0], sda_s}; bit_cnt++.
    - On the rise where bit_cnt==DEPTH-1: parallel_out <= {shift[DEPTH-2:0], sda_s} and data_valid=1 in the next cycle (1-cycle pulse). Then bit_cnt <= 0 -> ACK_SETUP.
  - ACK_SETUP:
    - On scl_fall: sda_oe <= ack_en -> ACK_HOLD.
  - ACK_HOLD: sda_oe is held through the SCL high phase.
    - On the first scl_fall after an scl_rise: sda_oe <= 0 -> RECV.
- Repeated START in RECV/ACK_SETUP/ACK_HOLD:
  - sda_oe <= 0; discard the partial word (no data_valid); bit_cnt=0, shift=0; stay/enter RECV.
- stop in any state: -> IDLE, sda_oe <= 0; partial word discarded, parallel_out unchanged.
- en=0: -> IDLE next cycle; sda_oe=0, bit_cnt=0; parallel_out retained; no pulses.
- parallel_out holds its value until the next completed word.
- sda_oe is never 1 outside ACK_SETUP -> ACK_HOLD, and only when ack_en was 1 at the scl_fall.
- ack_en is sampled only at the ACK_SETUP scl_fall; later changes have no effect on the current ACK.
- Mid-operation reset: all state is cleared the cycle after rst_n is sampled low; SDA is released immediately on that edge.

Test Plan:
- START, bits 1,0,1,0,0,1,0,1, ack_en=1 -> start_det pulse; data_valid pulse with parallel_out=8'hA5; sda_oe=1 from the 8th SCL fall to the 9th SCL fall, then 0.
- Same frame with ack_en=0, byte 8'h3C -> parallel_out=8'h3C, data_valid pulses, sda_oe stays 0 throughout.
- START, 4 bits, repeated START, byte 8'hFF -> two start_det pulses, exactly one data_valid with 8'hFF; the partial nibble is never visible.
- START, byte 8'h81 with ACK, 3 bits, STOP -> stop_det pulse; busy=0 within 4 clk of the SDA rise; parallel_out stays 8'h81; sda_oe=0.
- en deasserted mid-byte, then reasserted with a new START and byte 8'h5A -> IDLE on deassert, no pulses while en=0; then parallel_out=8'h5A.
- rst_n=0 during ACK_HOLD with sda_oe=1 -> sda_oe, busy, parallel_out=0 the next cycle; SCL/SDA toggling without START produces no data_valid.

Source files
------------

// File: rtl/i2c_sipo_rx.sv
// I2C slave receive deserializer: START/STOP detect, MSB-first shift-in, ACK/NACK drive.
// Pin events act 3 clk after a pin change and data_valid follows 1 clk later; there is no backpressure, so pulses are never held.
module i2c_sipo_rx #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             ack_en,
    output logic [DEPTH-1:0] parallel_out,
    output logic             data_valid,
    output logic             start_det,
    output logic             stop_det,
    output logic             sda_oe,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ACK_SETUP,
        ACK_HOLD
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;
    logic [DEPTH-1:0] parallel_q;
    logic             data_valid_q;
    logic             start_det_q;
    logic             stop_det_q;
    logic             sda_oe_q;
    logic             seen_rise_q;

    logic scl_meta_q, scl_s_q, scl_dly_q;
    logic sda_meta_q, sda_s_q, sda_dly_q;

    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    assign scl_rise = scl_s_q & ~scl_dly_q;
    assign scl_fall = ~scl_s_q & scl_dly_q;
    assign start_ev = sda_dly_q & ~sda_s_q & scl_s_q;
    assign stop_ev  = ~sda_dly_q & sda_s_q & scl_s_q;

    assign shift_d = {shift_q[DEPTH-2:0], sda_s_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_meta_q   <= 1'b0;
            scl_s_q      <= 1'b0;
            scl_dly_q    <= 1'b0;
            sda_meta_q   <= 1'b0;
            sda_s_q      <= 1'b0;
            sda_dly_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parallel_q   <= '0;
            data_valid_q <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            seen_rise_q  <= 1'b0;
        end else begin
            scl_meta_q   <= scl_in;
            scl_s_q      <= scl_meta_q;
            scl_dly_q    <= scl_s_q;
            sda_meta_q   <= sda_in;
            sda_s_q      <= sda_meta_q;
            sda_dly_q    <= sda_s_q;

            data_valid_q <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;

            if (!en) begin
                state_q     <= IDLE;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= '0;
                seen_rise_q <= 1'b0;
            end else if (stop_ev) begin
                // Partial word is dropped; parallel_q keeps the last complete word.
                stop_det_q  <= 1'b1;
                state_q     <= IDLE;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                seen_rise_q <= 1'b0;
            end else if (start_ev) begin
                start_det_q <= 1'b1;
                state_q     <= RECV;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                seen_rise_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    RECV: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            if (bit_cnt_q == LAST_BIT) begin
                                parallel_q   <= shift_d;
                                data_valid_q <= 1'b1;
                                bit_cnt_q    <= '0;
                                state_q      <= ACK_SETUP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ACK_SETUP: begin
                        if (scl_fall) begin
                            sda_oe_q    <= ack_en;
                            seen_rise_q <= 1'b0;
                            state_q     <= ACK_HOLD;
                        end
                    end
                    ACK_HOLD: begin
                        // Release only on the fall that closes the ACK clock pulse.
                        if (scl_rise) begin
                            seen_rise_q <= 1'b1;
                        end else if (scl_fall && seen_rise_q) begin
                            sda_oe_q    <= 1'b0;
                            seen_rise_q <= 1'b0;
                            state_q     <= RECV;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign parallel_out = parallel_q;
    assign data_valid   = data_valid_q;
    assign start_det    = start_det_q;
    assign stop_det     = stop_det_q;
    assign sda_oe       = sda_oe_q;
    assign busy         = (state_q != IDLE);

endmodule
